// File: rtl/vga_frame_capture.sv
// rtl/vga_frame_capture.sv - VGA receive-side timing lock and single-frame capture to RAM
module vga_frame_capture #(
  parameter int   H_TOTAL     = 800,
  parameter int   V_TOTAL     = 525,
  parameter int   H_START     = 144,
  parameter int   V_START     = 35,
  parameter int   H_ACTIVE    = 640,
  parameter int   V_ACTIVE    = 480,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic        vga_clk_i,
  input  logic        vga_rst_i,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [3:0]  vga_r,
  input  logic [3:0]  vga_g,
  input  logic [3:0]  vga_b,
  input  logic        cap_arm,
  input  logic        clr_err,
  output logic        locked,
  output logic        cap_busy,
  output logic        cap_we,
  output logic [18:0] cap_addr,
  output logic [11:0] cap_data,
  output logic        frame_done,
  output logic        cap_abort,
  output logic [31:0] frame_sum,
  output logic        h_err,
  output logic        v_err
);

  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [18:0] LAST_ADDR = 19'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_TRACK,
    ST_LOCKED
  } state_t;

  // first-stage input samples plus previous sync samples for edge detection
  logic        hs_q, hs_p_q, vs_q, vs_p_q;
  logic [11:0] rgb_q;
  logic        arm_q, clr_q;

  // position counters; hcount_d/vcount_d are the position of the pixel now in stage one
  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;

  state_t        state_q;
  logic [GW-1:0] good_q;
  logic          locked_q, pending_q, capt_q, busy_q;
  logic          cap_we_q, frame_done_q, cap_abort_q;
  logic [18:0]   cap_addr_q;
  logic [11:0]   cap_data_q;
  logic [31:0]   sum_q;
  logic          h_err_q, v_err_q;

  logic        hs_edge, vs_edge;
  logic        h_ev, v_ev, err_ev, tracking;
  logic        vis, start_cap, done_now;
  logic [31:0] h32, v32, col32, row32;
  logic [18:0] addr_d;

  // register every pin once; syncs reset to their idle level so release gives no false edge
  always_ff @(posedge vga_clk_i or posedge vga_rst_i) begin
    if (vga_rst_i) begin
      hs_q   <= ~SYNC_POL;
      hs_p_q <= ~SYNC_POL;
      vs_q   <= ~SYNC_POL;
      vs_p_q <= ~SYNC_POL;
      rgb_q  <= '0;
      arm_q  <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      hs_q   <= vga_hs;
      hs_p_q <= hs_q;
      vs_q   <= vga_vs;
      vs_p_q <= vs_q;
      rgb_q  <= {vga_r, vga_g, vga_b};
      arm_q  <= cap_arm;
      clr_q  <= clr_err;
    end
  end

  // edge detect, next position, timing-error events and visible-pixel address
  always_comb begin
    hs_edge  = (hs_q == SYNC_POL) && (hs_p_q != SYNC_POL);
    vs_edge  = (vs_q == SYNC_POL) && (vs_p_q != SYNC_POL);
    tracking = (state_q != ST_SEARCH);

    hcount_d = hcount_q;
    if (hs_edge) begin
      hcount_d = '0;
    end else if (hcount_q != HW'(H_TOTAL)) begin
      hcount_d = hcount_q + HW'(1);
    end

    vcount_d = vcount_q;
    if (vs_edge) begin
      vcount_d = '0;
    end else if (hs_edge && (vcount_q != VW'(V_TOTAL))) begin
      vcount_d = vcount_q + VW'(1);
    end

    // late edge or missing edge (count hitting the total) are both line-length errors
    if (hs_edge) begin
      h_ev = tracking && (hcount_q != HW'(H_TOTAL - 1));
    end else begin
      h_ev = tracking && (hcount_q == HW'(H_TOTAL - 1));
    end
    if (vs_edge) begin
      v_ev = tracking && (vcount_q != VW'(V_TOTAL - 1));
    end else begin
      v_ev = tracking && hs_edge && (vcount_q == VW'(V_TOTAL - 1));
    end
    err_ev = h_ev || v_ev;

    h32   = 32'(hcount_d);
    v32   = 32'(vcount_d);
    vis   = (h32 >= 32'(H_START)) && (h32 < 32'(H_START + H_ACTIVE)) &&
            (v32 >= 32'(V_START)) && (v32 < 32'(V_START + V_ACTIVE));
    col32 = h32 - 32'(H_START);
    row32 = v32 - 32'(V_START);
    addr_d = 19'(row32 * 32'(H_ACTIVE) + col32);

    start_cap = vs_edge && (state_q == ST_LOCKED) && !err_ev && pending_q;
    done_now  = cap_we_q && (cap_addr_q == LAST_ADDR);
  end

  // line and frame position counters
  always_ff @(posedge vga_clk_i or posedge vga_rst_i) begin
    if (vga_rst_i) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  // sticky error flags; a new error event overrides a simultaneous clear
  always_ff @(posedge vga_clk_i or posedge vga_rst_i) begin
    if (vga_rst_i) begin
      h_err_q <= 1'b0;
      v_err_q <= 1'b0;
    end else begin
      h_err_q <= h_ev || (h_err_q && !clr_q);
      v_err_q <= v_ev || (v_err_q && !clr_q);
    end
  end

  // lock state machine and capture sequencing with registered outputs
  always_ff @(posedge vga_clk_i or posedge vga_rst_i) begin
    if (vga_rst_i) begin
      state_q      <= ST_SEARCH;
      good_q       <= '0;
      locked_q     <= 1'b0;
      pending_q    <= 1'b0;
      capt_q       <= 1'b0;
      busy_q       <= 1'b0;
      cap_we_q     <= 1'b0;
      cap_addr_q   <= '0;
      cap_data_q   <= '0;
      sum_q        <= '0;
      frame_done_q <= 1'b0;
      cap_abort_q  <= 1'b0;
    end else begin
      cap_we_q     <= 1'b0;
      frame_done_q <= 1'b0;
      cap_abort_q  <= 1'b0;

      case (state_q)
        ST_SEARCH: begin
          if (vs_edge) begin
            state_q <= ST_TRACK;
            good_q  <= '0;
          end
        end
        ST_TRACK: begin
          if (err_ev) begin
            state_q <= ST_SEARCH;
            good_q  <= '0;
          end else if (vs_edge) begin
            if (good_q == GW'(LOCK_FRAMES - 1)) begin
              state_q  <= ST_LOCKED;
              locked_q <= 1'b1;
              good_q   <= '0;
            end else begin
              good_q <= good_q + GW'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (err_ev) begin
            state_q  <= ST_SEARCH;
            locked_q <= 1'b0;
            good_q   <= '0;
          end
        end
        default: begin
          state_q  <= ST_SEARCH;
          locked_q <= 1'b0;
          good_q   <= '0;
        end
      endcase

      // a completed last write takes priority over an error arriving just after it
      if (done_now) begin
        frame_done_q <= 1'b1;
        capt_q       <= 1'b0;
        busy_q       <= 1'b0;
      end else if (capt_q && err_ev) begin
        cap_abort_q <= 1'b1;
        capt_q      <= 1'b0;
        pending_q   <= 1'b0;
        busy_q      <= 1'b0;
      end else if (start_cap) begin
        capt_q    <= 1'b1;
        pending_q <= 1'b0;
        sum_q     <= '0;
      end else if (capt_q && vis) begin
        cap_we_q   <= 1'b1;
        cap_addr_q <= addr_d;
        cap_data_q <= rgb_q;
        sum_q      <= sum_q + 32'(rgb_q);
      end

      // arming is only honoured when nothing is pending or running
      if (arm_q && !busy_q) begin
        pending_q <= 1'b1;
        busy_q    <= 1'b1;
      end
    end
  end

  assign locked     = locked_q;
  assign cap_busy   = busy_q;
  assign cap_we     = cap_we_q;
  assign cap_addr   = cap_addr_q;
  assign cap_data   = cap_data_q;
  assign frame_done = frame_done_q;
  assign cap_abort  = cap_abort_q;
  assign frame_sum  = sum_q;
  assign h_err      = h_err_q;
  assign v_err      = v_err_q;

endmodule

// File: tb/tb_vga_frame_capture.sv
// tb/tb_vga_frame_capture.sv - directed self-checking bench for vga_frame_capture on reduced timing
module tb_vga_frame_capture;

  localparam int HT  = 20;
  localparam int VT  = 10;
  localparam int HS  = 4;
  localparam int VS  = 2;
  localparam int HA  = 8;
  localparam int VA  = 6;
  localparam int HSW = 2;

  logic        clk, rst;
  logic        vga_hs, vga_vs;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        cap_arm, clr_err;
  logic        locked, cap_busy, cap_we, frame_done, cap_abort, h_err, v_err;
  logic [18:0] cap_addr;
  logic [11:0] cap_data;
  logic [31:0] frame_sum;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int last_vs_cyc = 0;
  int lock_cyc = -1;
  int wr_cnt = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int addr_bad = 0;
  int data_bad = 0;
  int exp_addr = 0;
  bit lk_prev = 1'b0;
  int wr0;

  vga_frame_capture #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS),
    .H_ACTIVE(HA), .V_ACTIVE(VA), .SYNC_POL(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .vga_clk_i(clk), .vga_rst_i(rst), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .cap_arm(cap_arm), .clr_err(clr_err),
    .locked(locked), .cap_busy(cap_busy), .cap_we(cap_we),
    .cap_addr(cap_addr), .cap_data(cap_data),
    .frame_done(frame_done), .cap_abort(cap_abort),
    .frame_sum(frame_sum), .h_err(h_err), .v_err(v_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // write stream observer: address order and pixel content, pulse counts, first lock time
  always @(negedge clk) begin
    if (rst) begin
      exp_addr = 0;
    end else begin
      if (cap_we) begin
        if (32'(cap_addr) != exp_addr) addr_bad++;
        if (32'(cap_data) != ((exp_addr / HA) * 16 + (exp_addr % HA))) data_bad++;
        exp_addr++;
        wr_cnt++;
      end
      if (frame_done) begin
        done_cnt++;
        exp_addr = 0;
      end
      if (cap_abort) begin
        abort_cnt++;
        exp_addr = 0;
      end
      if (locked && !lk_prev && lock_cyc < 0) lock_cyc = cyc;
      lk_prev = locked;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // drive nlines lines of a frame; line short_ln is one clock short; optional arm/clear pulse on line 0
  task automatic send_frame(input int nlines, input int short_ln, input bit arm, input bit clr);
    int len;
    bit vis;
    for (int ln = 0; ln < nlines; ln++) begin
      len = (ln == short_ln) ? HT - 1 : HT;
      for (int pc = 0; pc < len; pc++) begin
        vga_hs = (pc < HSW) ? 1'b0 : 1'b1;
        vga_vs = (ln == 0) ? 1'b0 : 1'b1;
        vis = (pc >= HS) && (pc < HS + HA) && (ln >= VS) && (ln < VS + VA);
        if (vis) begin
          vga_r = 4'h0;
          vga_g = 4'(ln - VS);
          vga_b = 4'(pc - HS);
        end else begin
          {vga_r, vga_g, vga_b} = 12'hFFF;
        end
        cap_arm = arm && (ln == 0) && (pc == 5);
        clr_err = clr && (ln == 0) && (pc == 5);
        if (ln == 0 && pc == 0) last_vs_cyc = cyc;
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    vga_hs = 1'b1;
    vga_vs = 1'b1;
    {vga_r, vga_g, vga_b} = 12'h000;
    cap_arm = 1'b0;
    clr_err = 1'b0;
    #12;
    check_eq("rst_flags", 32'({locked, cap_busy, cap_we, frame_done, cap_abort, h_err, v_err}), 0);
    check_eq("rst_addr", 32'(cap_addr), 0);
    check_eq("rst_data", 32'(cap_data), 0);
    check_eq("rst_sum", frame_sum, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end

    // ideal timing, three frames to lock
    send_frame(VT, -1, 0, 0);
    send_frame(VT, -1, 0, 0);
    check_eq("pre_lock", 32'(locked), 0);
    send_frame(VT, -1, 0, 0);
    check_eq("lock", 32'(locked), 1);
    check_eq("lock_time", lock_cyc, last_vs_cyc + 2);
    check_eq("t1_errs", 32'({h_err, v_err}), 0);

    // armed while locked: full capture on the following frame
    wr0 = wr_cnt;
    send_frame(VT, -1, 1, 0);
    check_eq("t2_busy", 32'(cap_busy), 1);
    check_eq("t2_nowr", wr_cnt - wr0, 0);
    send_frame(VT, -1, 0, 0);
    check_eq("t2_writes", wr_cnt - wr0, HA * VA);
    check_eq("t2_done", done_cnt, 1);
    check_eq("t2_sum", frame_sum, 2088);
    check_eq("t2_busy_end", 32'(cap_busy), 0);
    check_eq("t2_abort", abort_cnt, 0);

    // one short line while locked, clear, relock
    send_frame(VT, 3, 0, 0);
    check_eq("t3_herr", 32'(h_err), 1);
    check_eq("t3_verr", 32'(v_err), 0);
    check_eq("t3_unlock", 32'(locked), 0);
    send_frame(VT, -1, 0, 1);
    check_eq("t3_clr", 32'(h_err), 0);
    send_frame(VT, -1, 0, 0);
    check_eq("t3_still_unlk", 32'(locked), 0);
    send_frame(VT, -1, 0, 0);
    check_eq("t3_relock", 32'(locked), 1);

    // short frame in the middle of a capture
    wr0 = wr_cnt;
    send_frame(VT, -1, 1, 0);
    send_frame(5, -1, 0, 0);
    send_frame(VT, -1, 0, 0);
    check_eq("t4_verr", 32'(v_err), 1);
    check_eq("t4_abort", abort_cnt, 1);
    check_eq("t4_busy", 32'(cap_busy), 0);
    check_eq("t4_done", done_cnt, 1);
    check_eq("t4_writes", wr_cnt - wr0, 24);
    check_eq("t4_sum", frame_sum, 468);
    check_eq("t4_unlock", 32'(locked), 0);

    // armed before lock: waits, then captures on the frame after lock
    wr0 = wr_cnt;
    send_frame(VT, -1, 1, 0);
    check_eq("t5_busy", 32'(cap_busy), 1);
    send_frame(VT, -1, 0, 0);
    send_frame(VT, -1, 0, 0);
    check_eq("t5_lock", 32'(locked), 1);
    check_eq("t5_nowr", wr_cnt - wr0, 0);
    send_frame(VT, -1, 0, 0);
    check_eq("t5_writes", wr_cnt - wr0, HA * VA);
    check_eq("t5_done", done_cnt, 2);
    check_eq("t5_sum", frame_sum, 2088);

    // reset in the middle of a capture
    wr0 = wr_cnt;
    send_frame(VT, -1, 1, 0);
    send_frame(4, -1, 0, 0);
    check_eq("t6_busy", 32'(cap_busy), 1);
    check_eq("t6_writes", wr_cnt - wr0, 16);
    check_eq("t6_psum", frame_sum, 184);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_flags", 32'({locked, cap_busy, cap_we, frame_done, cap_abort, h_err, v_err}), 0);
    check_eq("t6_addr", 32'(cap_addr), 0);
    check_eq("t6_sum", frame_sum, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_frame(VT, -1, 0, 0);
    send_frame(VT, -1, 0, 0);
    check_eq("t6_unlk", 32'(locked), 0);
    send_frame(VT, -1, 0, 0);
    check_eq("t6_relock", 32'(locked), 1);
    check_eq("t6_pulses", 32'(done_cnt * 16 + abort_cnt), 2 * 16 + 1);
    check_eq("t6_busy_end", 32'(cap_busy), 0);

    check_eq("addr_order", addr_bad, 0);
    check_eq("pixel_data", data_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
